// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch constants,
// opcode/funct encodings and the fetch buffer entry layout.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int FIFO_DEPTH = 2;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    typedef enum logic [5:0] {
        OP_ALU = 6'd7,
        OP_LW  = 6'd8,
        OP_SW  = 6'd9
    } opcode_e;

    typedef enum logic [5:0] {
        FUNCT_ADD = 6'd32,
        FUNCT_SUB = 6'd34,
        FUNCT_AND = 6'd36,
        FUNCT_OR  = 6'd37,
        FUNCT_MUL = 6'd50
    } funct_e;

    // Opcode 63 is unassigned; decode maps it to a no-write AND on r31.
    localparam logic [DATA_W-1:0] NOP_WORD = {6'h3F, 26'd0};

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input,
// decode-side valid/ready port and the sticky protocol error flag.
interface instr_fetch_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
    logic              err;

    // Fetch stage side.
    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        output err
    );

    // Memory / decode / branch-unit side.
    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        input  err
    );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries.
// Flush empties it in one cycle and overrides any push or pop that cycle.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Write the incoming entry into the slot at the write pointer.
    // NOTE: storage has no reset; count gates every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers returned words with their PC and hands them to decode.
// A redirect reloads the PC, flushes the buffer and drops any in-flight word.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter int                FIFO_DEPTH = cpu_pkg::FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              discard;
    logic              run;
    logic              err_q;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    logic              req;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;
    logic              valid;

    // run holds requests off until the first clock after reset release,
    // so imem_req reads 0 throughout reset.
    assign req    = run && !outstanding && (count < CW'(FIFO_DEPTH)) && !bus.redirect_valid;
    assign accept = req && bus.imem_gnt;
    assign resp   = bus.imem_rvalid && outstanding;
    assign push   = resp && !discard && !bus.redirect_valid;
    assign valid  = (count != '0);
    assign pop    = valid && bus.instr_ready;

    // PC, in-flight tracking, redirect discard and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            run         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            run <= 1'b1;
            if (bus.imem_rvalid && !outstanding) err_q <= 1'b1;

            if (bus.redirect_valid) begin
                pc <= bus.redirect_pc;
            end else if (accept) begin
                pc     <= next_pc(pc);
                req_pc <= pc;
            end

            if (accept)    outstanding <= 1'b1;
            else if (resp) outstanding <= 1'b0;

            // A word still in flight at redirect time belongs to the old path.
            if (bus.redirect_valid) discard <= outstanding && !bus.imem_rvalid;
            else if (resp)          discard <= 1'b0;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({bus.imem_rdata, req_pc}),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .count     (count),
        .head      (head)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head.instr : '0;
    assign bus.instr_pc    = valid ? head.pc    : '0;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming fetch, back-pressure, redirects
// against in-flight and returning words, PC wrap, error flag and async reset.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory response: automatic responder or hand-driven pulses.
    logic        auto_mem = 1'b1;
    logic        auto_rvalid = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    assign bus.imem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
    assign bus.imem_rdata  = auto_mem ? auto_rdata  : man_rdata;

    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    int          n_got;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Single-cycle memory: answers one cycle after each accepted request.
    initial begin
        logic        hit;
        logic [31:0] haddr;
        forever begin
            @(posedge clk);
            if (auto_mem) begin
                hit   = bus.imem_req && bus.imem_gnt;
                haddr = bus.imem_addr;
                #1;
                auto_rvalid = hit;
                auto_rdata  = hit ? mem_word(haddr) : '0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Score handshakes that will complete at the coming edge.
    task automatic observe();
        if (bus.imem_req && bus.imem_gnt) begin
            check("imem_addr", 64'(bus.imem_addr), 64'(exp_addr));
            exp_addr = exp_addr + 32'd4;
        end
        if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
            check("instr_pc", 64'(bus.instr_pc), 64'(exp_pc));
            check("instr", 64'(bus.instr), 64'(mem_word(exp_pc)));
            exp_pc = exp_pc + 32'd4;
            n_got++;
        end
    endtask

    task automatic step();
        tick();
        observe();
    endtask

    task automatic wait_valid(input string tag);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = bus.instr_valid;
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        logic got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            got = bus.imem_req && (bus.imem_addr == addr);
        end
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        bus.imem_gnt = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;
        exp_addr = 32'h0;
        exp_pc   = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        exp_addr = 32'h0;
        exp_pc   = 32'h0;
        n_got    = 0;

        // Reset state.
        #3;
        check("rst imem_req",    64'(bus.imem_req),    64'd0);
        check("rst imem_addr",   64'(bus.imem_addr),   64'd0);
        check("rst instr_valid", 64'(bus.instr_valid), 64'd0);
        check("rst instr",       64'(bus.instr),       64'd0);
        check("rst instr_pc",    64'(bus.instr_pc),    64'd0);
        check("rst err",         64'(bus.err),         64'd0);
        tick();
        rst_n = 1'b1;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;

        // Streaming: one instruction every two cycles, pc 0,4,8...
        for (int i = 0; i < 20; i++) step();
        check("stream count", 64'(n_got), 64'd9);

        // Back-pressure: FIFO fills to two entries and requests stop.
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full imem_req",    64'(bus.imem_req),    64'd0);
        check("full instr_valid", 64'(bus.instr_valid), 64'd1);
        check("full head pc",     64'(bus.instr_pc),    64'h24);
        check("full head instr",  64'(bus.instr),       64'(mem_word(32'h24)));
        bus.instr_ready = 1'b1;
        observe();
        for (int i = 0; i < 8; i++) step();

        // Redirect while the fetch of 0x8 is in flight.
        do_reset();
        wait_req("wait req 0x8", 32'h8);
        auto_mem = 1'b0;
        step();
        check("inflight imem_req", 64'(bus.imem_req), 64'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        exp_addr = 32'h100;
        exp_pc   = 32'h100;
        tick();
        check("redir instr_valid", 64'(bus.instr_valid), 64'd0);
        bus.redirect_valid = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = mem_word(32'h8);
        tick();
        check("stale dropped",   64'(bus.instr_valid), 64'd0);
        check("redir imem_req",  64'(bus.imem_req),    64'd1);
        check("redir imem_addr", 64'(bus.imem_addr),   64'h100);
        check("redir err",       64'(bus.err),         64'd0);
        man_rvalid      = 1'b0;
        bus.instr_ready = 1'b0;
        auto_mem        = 1'b1;
        observe();
        wait_valid("wait 0x100");
        check("redir instr_pc", 64'(bus.instr_pc), 64'h100);
        check("redir instr",    64'(bus.instr),    64'(mem_word(32'h100)));

        // Redirect coincident with rvalid of 0x104 and with a pop of 0x100.
        auto_mem = 1'b0;
        tick();
        check("coinc imem_req",    64'(bus.imem_req),    64'd0);
        check("coinc instr_valid", 64'(bus.instr_valid), 64'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        bus.instr_ready    = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = mem_word(32'h104);
        exp_addr = 32'h200;
        exp_pc   = 32'h200;
        #1;
        check("coinc req blocked", 64'(bus.imem_req), 64'd0);
        tick();
        check("flush instr_valid", 64'(bus.instr_valid), 64'd0);
        check("flush instr",       64'(bus.instr),       64'd0);
        check("flush instr_pc",    64'(bus.instr_pc),    64'd0);
        check("flush err",         64'(bus.err),         64'd0);
        bus.redirect_valid = 1'b0;
        man_rvalid = 1'b0;
        auto_mem   = 1'b1;
        #1;
        check("flush imem_req",  64'(bus.imem_req),  64'd1);
        check("flush imem_addr", 64'(bus.imem_addr), 64'h200);
        observe();
        wait_valid("wait 0x200");
        check("after flush instr_pc", 64'(bus.instr_pc), 64'h200);

        // PC wrap at the top of the address space; address held while gnt low.
        bus.imem_gnt = 1'b0;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("stall imem_req",  64'(bus.imem_req),  64'd1);
            check("stall imem_addr", 64'(bus.imem_addr), 64'hFFFF_FFFC);
            tick();
        end
        bus.imem_gnt = 1'b1;
        exp_addr = 32'hFFFF_FFFC;
        exp_pc   = 32'hFFFF_FFFC;
        observe();
        wait_valid("wait wrap");
        check("wrap instr_pc",  64'(bus.instr_pc),  64'hFFFF_FFFC);
        check("wrap instr",     64'(bus.instr),     64'(mem_word(32'hFFFF_FFFC)));
        check("wrap imem_addr", 64'(bus.imem_addr), 64'h0);

        // Unsolicited rvalid sets the sticky error flag.
        bus.imem_gnt = 1'b0;
        auto_mem     = 1'b0;
        tick();
        tick();
        check("pre err", 64'(bus.err), 64'd0);
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        tick();
        man_rvalid = 1'b0;
        check("err set", 64'(bus.err), 64'd1);
        tick();
        tick();
        tick();
        check("err sticky", 64'(bus.err), 64'd1);

        // Mid-fetch asynchronous reset clears every output at once.
        auto_mem        = 1'b1;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b0;
        tick();
        tick();
        tick();
        check("pre-rst instr_valid", 64'(bus.instr_valid), 64'd1);
        check("pre-rst instr_pc",    64'(bus.instr_pc),    64'h0);
        check("pre-rst instr",       64'(bus.instr),       64'(mem_word(32'h0)));
        #3;
        rst_n = 1'b0;
        #1;
        check("async imem_req",    64'(bus.imem_req),    64'd0);
        check("async imem_addr",   64'(bus.imem_addr),   64'd0);
        check("async instr_valid", 64'(bus.instr_valid), 64'd0);
        check("async instr",       64'(bus.instr),       64'd0);
        check("async instr_pc",    64'(bus.instr_pc),    64'd0);
        check("async err",         64'(bus.err),         64'd0);
        auto_mem     = 1'b0;
        man_rvalid   = 1'b0;
        bus.imem_gnt = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post-rst err", 64'(bus.err), 64'd0);
        man_rvalid = 1'b1;
        tick();
        man_rvalid = 1'b0;
        check("post-rst stray rvalid err", 64'(bus.err), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
